// File: rtl/dmem_pkg.sv
// Shared constants and loader state encoding for the data-memory responder.
package dmem_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_DEPTH  = 64;
    localparam int DEF_ADDR_W = 6;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSEMBLE = 2'd1,
        COMMIT   = 2'd2
    } ld_state_t;

endpackage

// File: rtl/dmem_loader.sv
// Byte-stream loader: packs little-endian bytes into words and requests
// memory writes; the CPU port always wins, so the write request waits for grant.
module dmem_loader
    import dmem_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              valid,
    input  logic [7:0]        data,
    input  logic              last,
    input  logic              grant,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WIDTH-1:0]  wr_data
);

    ld_state_t         state, state_n;
    logic [ADDR_W-1:0] ptr, ptr_n;
    logic [1:0]        lane, lane_n;
    logic [WIDTH-1:0]  buffer, buffer_n;
    logic [ADDR_W:0]   words_n;
    logic              last_seen, last_seen_n;
    logic              done_n;

    assign wr_addr = ptr;
    assign wr_data = buffer;

    // State register; reset drops any session in progress without a done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Datapath registers that follow the next-state logic below.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr       <= '0;
            lane      <= '0;
            buffer    <= '0;
            words     <= '0;
            last_seen <= 1'b0;
            done      <= 1'b0;
        end else begin
            ptr       <= ptr_n;
            lane      <= lane_n;
            buffer    <= buffer_n;
            words     <= words_n;
            last_seen <= last_seen_n;
            done      <= done_n;
        end
    end

    // Next-state and outputs; a restart pulse overrides any byte or commit.
    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        lane_n      = lane;
        buffer_n    = buffer;
        words_n     = words;
        last_seen_n = last_seen;
        done_n      = 1'b0;
        ready       = 1'b0;
        busy        = 1'b0;
        wr_valid    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n     = ASSEMBLE;
                    ptr_n       = '0;
                    lane_n      = '0;
                    buffer_n    = '0;
                    words_n     = '0;
                    last_seen_n = 1'b0;
                end
            end

            ASSEMBLE: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (start) begin
                    ptr_n       = '0;
                    lane_n      = '0;
                    buffer_n    = '0;
                    words_n     = '0;
                    last_seen_n = 1'b0;
                end else if (valid) begin
                    buffer_n[{lane, 3'b000} +: 8] = data;
                    lane_n      = lane + 2'd1;
                    last_seen_n = last;
                    if (lane == 2'd3 || last) begin
                        state_n = COMMIT;
                    end
                end
            end

            COMMIT: begin
                busy = 1'b1;
                if (start) begin
                    state_n     = ASSEMBLE;
                    ptr_n       = '0;
                    lane_n      = '0;
                    buffer_n    = '0;
                    words_n     = '0;
                    last_seen_n = 1'b0;
                end else begin
                    wr_valid = 1'b1;
                    if (grant) begin
                        words_n     = words + {{ADDR_W{1'b0}}, 1'b1};
                        lane_n      = '0;
                        buffer_n    = '0;
                        last_seen_n = 1'b0;
                        if (last_seen || ptr == ADDR_W'(DEPTH - 1)) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end else begin
                            state_n = ASSEMBLE;
                            ptr_n   = ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data memory with a zero-latency CPU port and a byte-stream loader that
// fills it in the cycles the CPU is not storing.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [$clog2(DEPTH)-1:0]   dmem_addr,
    input  logic                       dmem_w_en,
    input  logic [WIDTH-1:0]           dmem_wdata,
    output logic [WIDTH-1:0]           dmem_rdata,
    input  logic                       ld_start,
    input  logic                       ld_valid,
    input  logic [7:0]                 ld_data,
    input  logic                       ld_last,
    output logic                       ld_ready,
    output logic                       ld_busy,
    output logic                       ld_done,
    output logic [$clog2(DEPTH):0]     ld_words
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;

    dmem_loader #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_loader (
        .clk      (clk),
        .reset    (reset),
        .start    (ld_start),
        .valid    (ld_valid),
        .data     (ld_data),
        .last     (ld_last),
        .grant    (~dmem_w_en),
        .ready    (ld_ready),
        .busy     (ld_busy),
        .done     (ld_done),
        .words    (ld_words),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    assign dmem_rdata = mem[dmem_addr];

    // Single write port: CPU stores take the cycle, the loader only writes when granted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (dmem_w_en) begin
            mem[dmem_addr] <= dmem_wdata;
        end else if (wr_valid) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with hand-computed expected values.
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic [5:0]  dmem_addr;
    logic        dmem_w_en;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        ld_busy;
    logic        ld_done;
    logic [6:0]  ld_words;

    int checks   = 0;
    int failures = 0;

    dmem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .dmem_addr  (dmem_addr),
        .dmem_w_en  (dmem_w_en),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .ld_start   (ld_start),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .ld_busy    (ld_busy),
        .ld_done    (ld_done),
        .ld_words   (ld_words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares one observed value against the expected value and tallies it.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [5:0] addr, input logic w_en, input logic [31:0] wdata);
        dmem_addr  = addr;
        dmem_w_en  = w_en;
        dmem_wdata = wdata;
    endtask

    task automatic pulseStart();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input logic last);
        ld_valid = 1'b1;
        ld_data  = b;
        ld_last  = last;
        for (int n = 0; n < 20 && !ld_ready; n++) tick();
        if (!ld_ready) checkOutput("ready_wait", 32'(ld_ready), 32'd1);
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic readCheck(input string tag, input logic [5:0] addr, input logic [31:0] expected);
        dmem_addr = addr;
        @(negedge clk);
        checkOutput(tag, dmem_rdata, expected);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0;
        applyStimulus(6'd0, 1'b0, 32'h0);
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_data  = 8'h00;
        ld_last  = 1'b0;

        // Reset state
        tick();
        tick();
        checkOutput("rst_ready", 32'(ld_ready), 32'd0);
        checkOutput("rst_busy",  32'(ld_busy),  32'd0);
        checkOutput("rst_done",  32'(ld_done),  32'd0);
        checkOutput("rst_rdata", dmem_rdata,    32'h0);
        reset = 1'b1;
        tick();
        checkOutput("idle_words", 32'(ld_words), 32'd0);

        // CPU store: old data same cycle, new data next cycle
        applyStimulus(6'd5, 1'b1, 32'hDEADBEEF);
        #1;
        checkOutput("store_old", dmem_rdata, 32'h0);
        tick();
        applyStimulus(6'd5, 1'b0, 32'h0);
        #1;
        checkOutput("store_new", dmem_rdata, 32'hDEADBEEF);

        // Basic session with a short final word
        tick();
        pulseStart();
        checkOutput("s1_ready", 32'(ld_ready), 32'd1);
        checkOutput("s1_busy",  32'(ld_busy),  32'd1);
        sendByte(8'h11, 1'b0);
        sendByte(8'h22, 1'b0);
        sendByte(8'h33, 1'b0);
        sendByte(8'h44, 1'b0);
        checkOutput("s1_commit_ready", 32'(ld_ready), 32'd0);
        sendByte(8'h55, 1'b1);
        checkOutput("s1_words1", 32'(ld_words), 32'd1);
        tick();
        checkOutput("s1_done",  32'(ld_done),  32'd1);
        checkOutput("s1_words", 32'(ld_words), 32'd2);
        checkOutput("s1_idle",  32'(ld_busy),  32'd0);
        tick();
        checkOutput("s1_done_clr", 32'(ld_done), 32'd0);
        readCheck("s1_mem0", 6'd0, 32'h44332211);
        readCheck("s1_mem1", 6'd1, 32'h00000055);

        // CPU store stalls the loader commit to the same address; loader data wins
        tick();
        pulseStart();
        sendByte(8'hA1, 1'b0);
        sendByte(8'hA2, 1'b0);
        sendByte(8'hA3, 1'b0);
        sendByte(8'hA4, 1'b0);
        applyStimulus(6'd0, 1'b1, 32'h12345678);
        ld_valid = 1'b1;
        ld_data  = 8'hEE;
        for (int c = 0; c < 3; c++) begin
            checkOutput($sformatf("stall_ready%0d", c), 32'(ld_ready), 32'd0);
            tick();
        end
        applyStimulus(6'd0, 1'b0, 32'h0);
        ld_valid = 1'b0;
        #1;
        checkOutput("stall_cpu_data", dmem_rdata, 32'h12345678);
        checkOutput("stall_busy", 32'(ld_busy), 32'd1);
        tick();
        checkOutput("stall_commit_ready", 32'(ld_ready), 32'd1);
        checkOutput("stall_words", 32'(ld_words), 32'd1);
        readCheck("stall_mem0", 6'd0, 32'hA4A3A2A1);
        sendByte(8'hB1, 1'b0);
        sendByte(8'hB2, 1'b0);
        sendByte(8'hB3, 1'b0);
        sendByte(8'hB4, 1'b1);
        tick();
        checkOutput("stall_done",   32'(ld_done),  32'd1);
        checkOutput("stall_words2", 32'(ld_words), 32'd2);
        readCheck("stall_mem1", 6'd1, 32'hB4B3B2B1);

        // Restart mid-word discards the partial buffer
        tick();
        pulseStart();
        sendByte(8'hC1, 1'b0);
        sendByte(8'hC2, 1'b0);
        sendByte(8'hC3, 1'b0);
        sendByte(8'hC4, 1'b0);
        sendByte(8'hD1, 1'b0);
        sendByte(8'hD2, 1'b0);
        pulseStart();
        checkOutput("rs_words0", 32'(ld_words), 32'd0);
        checkOutput("rs_ready",  32'(ld_ready), 32'd1);
        sendByte(8'hE1, 1'b0);
        sendByte(8'hE2, 1'b0);
        sendByte(8'hE3, 1'b0);
        sendByte(8'hE4, 1'b1);
        tick();
        checkOutput("rs_done",  32'(ld_done),  32'd1);
        checkOutput("rs_words", 32'(ld_words), 32'd1);
        readCheck("rs_mem0", 6'd0, 32'hE4E3E2E1);
        readCheck("rs_mem1", 6'd1, 32'hB4B3B2B1);

        // Full 256-byte stream without ld_last ends at the last word
        tick();
        pulseStart();
        for (int i = 0; i < 256; i++) begin
            sendByte(8'(i), 1'b0);
        end
        checkOutput("full_commit_busy", 32'(ld_busy), 32'd1);
        tick();
        checkOutput("full_done",  32'(ld_done),  32'd1);
        checkOutput("full_words", 32'(ld_words), 32'd64);
        checkOutput("full_ready", 32'(ld_ready), 32'd0);
        tick();
        checkOutput("full_done_clr", 32'(ld_done),  32'd0);
        checkOutput("full_words_hold", 32'(ld_words), 32'd64);
        readCheck("full_mem0",  6'd0,  32'h03020100);
        readCheck("full_mem1",  6'd1,  32'h07060504);
        readCheck("full_mem63", 6'd63, 32'hFFFEFDFC);

        // Reset in the middle of a session
        tick();
        pulseStart();
        sendByte(8'h99, 1'b0);
        sendByte(8'h98, 1'b0);
        checkOutput("mr_busy_before", 32'(ld_busy), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("mr_busy",  32'(ld_busy),  32'd0);
        checkOutput("mr_ready", 32'(ld_ready), 32'd0);
        readCheck("mr_mem63", 6'd63, 32'h0);
        tick();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput($sformatf("mr_no_done%0d", c), 32'(ld_done), 32'd0);
        end
        checkOutput("mr_words", 32'(ld_words), 32'd0);
        readCheck("mr_mem0", 6'd0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
